tx_handshake_ctrl: RTL and testbench
====================================

// Module: tx_handshake_ctrl
// PURPOSE
//  Sender-side stop-and-wait controller for the TSPIN link. Sequences one data
//  packet send through the parallel serializer, then waits for a matching ACK
//  handshake packet from the receive-side header decoder. Resends on timeout,
//  tracks the 1-bit sequence number, and reports success or failure to game logic.
// PARAMETERS
//  TIMEOUT_CYCLES  100  cycles spent in WAIT_ACK before a resend (>=2)
//  MAX_RETRIES     3    resends allowed after the first send before failure (>=0)
//  TMR_W  $clog2(TIMEOUT_CYCLES)   width of the ACK timer (localparam)
//  RTY_W  $clog2(MAX_RETRIES+1)+1  width of the retry counter (localparam)
// PORTS
//  clk          in   1      system clock; all state changes on its rising edge
//  rst_l        in   1      asynchronous reset, active low
//  send_req     in   1      game logic requests send of the current data_pkt_t
//  send_ready   out  1      1 iff state==IDLE; a send_req is accepted only while this is high
//  tx_start     out  1      one-cycle pulse telling the serializer to emit all lanes
//  tx_seq_num   out  1      sequence number for the serializer/header; stable outside IDLE
//  tx_done      in   1      serializer pulse: last bit of the data packet has left
//  ack_valid    in   1      decoded, complement-checked handshake header is valid this cycle
//  ack_pid      in   1      pid_t of that header (PID_ACK=1, PID_GE=0)
//  ack_seq_num  in   1      seqNum of that header
//  send_done    out  1      one-cycle pulse: matching ACK received
//  send_fail    out  1      one-cycle pulse: retries exhausted, packet abandoned
//  retry_cnt    out  RTY_W  resends issued for the current packet
// BEHAVIOUR
//  Reset (async, rst_l=0): state=IDLE, tx_seq_num=0, tx_start=0, send_done=0,
//   send_fail=0, retry_cnt=0, timer=0. send_ready=1 follows from IDLE.
//  All outputs are registered, except send_ready, which is decoded from state.
//  FSM states: IDLE, SEND, WAIT_TX, WAIT_ACK.
//  IDLE:     send_req=1 -> SEND and retry_cnt<=0. Otherwise hold.
//  SEND:     tx_start=1 for exactly this one cycle, then -> WAIT_TX.
//            tx_start therefore rises 1 cycle after send_req is accepted.
//  WAIT_TX:  hold until tx_done=1, then -> WAIT_ACK with timer<=0.
//            ack_valid is ignored in this state.
//  WAIT_ACK: timer increments every cycle.
//   - ack_valid & ack_pid==PID_ACK & ack_seq_num==tx_seq_num:
//     send_done pulses next cycle, tx_seq_num toggles, -> IDLE.
//   - Any other ack_valid (PID_GE or wrong seq): ignored; timer keeps running.
//   - Timeout when timer==TIMEOUT_CYCLES-1 (WAIT_ACK lasts exactly TIMEOUT_CYCLES cycles):
//     - retry_cnt<MAX_RETRIES: retry_cnt++, -> SEND (resend uses the same seq).
//     - otherwise: send_fail pulses, -> IDLE, tx_seq_num unchanged, retry_cnt held
//       until the next accepted send.
//   - Matching ACK in the timeout cycle: the ACK wins (success, no resend).
//  send_req outside IDLE: ignored, not queued. tx_done outside WAIT_TX: ignored.
//  send_done and send_fail are never high together. Each is high for 1 cycle only.
//  Async reset mid-operation aborts the packet immediately. No pulse is generated.
// TESTING
//  1 Reset, send_req@c0, tx_done@c5, matching ACK (seq0)@c20 -> tx_start@c1 only,
//    send_done@c21, tx_seq_num=1, send_ready=1 from c21.
//  2 No ACK, TIMEOUT_CYCLES=100 -> tx_start again exactly 101 cycles after the
//    tx_done cycle, retry_cnt=1, same tx_seq_num=0.
//  3 No ACK ever, MAX_RETRIES=3 -> 4 tx_start pulses total, then one send_fail
//    pulse, retry_cnt=3, tx_seq_num unchanged, back in IDLE.
//  4 In WAIT_ACK: ACK with seq1 and a PID_GE header -> both ignored; then a seq0
//    PID_ACK -> send_done. Also: a matching ACK in the timeout cycle -> send_done,
//    no tx_start.
//  5 send_req held high during WAIT_TX/WAIT_ACK -> no extra tx_start. After success
//    and return to IDLE with send_req still high -> new send with seq toggled.
//  6 rst_l low during WAIT_ACK -> all outputs are at reset values asynchronously;
//    no send_done or send_fail after release.

Source files
------------

// File: rtl/tx_handshake_ctrl.sv
// tx_handshake_ctrl: stop-and-wait sender for the TSPIN link.
// Sends one packet, waits for a matching ACK, resends on timeout.
module tx_handshake_ctrl #(
  parameter int TIMEOUT_CYCLES = 100,
  parameter int MAX_RETRIES    = 3
) (
  input  logic clk,
  input  logic rst_l,
  input  logic send_req,
  output logic send_ready,
  output logic tx_start,
  output logic tx_seq_num,
  input  logic tx_done,
  input  logic ack_valid,
  input  logic ack_pid,
  input  logic ack_seq_num,
  output logic send_done,
  output logic send_fail,
  output logic [$clog2(MAX_RETRIES+1):0] retry_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam int RTY_W = $clog2(MAX_RETRIES+1) + 1;
  localparam logic PID_ACK = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_TX,
    WAIT_ACK
  } state_t;

  state_t           r_state;
  logic [TMR_W-1:0] r_tmr;
  logic [RTY_W-1:0] r_rty;
  logic             r_seq;
  logic             r_tx_start;
  logic             r_done;
  logic             r_fail;

  logic w_ack_match;
  logic w_timeout;
  logic w_can_retry;

  assign w_ack_match = ack_valid
                     & (ack_pid == PID_ACK)
                     & (ack_seq_num == r_seq);
  assign w_timeout   = (r_tmr == TMR_W'(TIMEOUT_CYCLES - 1));
  assign w_can_retry = (r_rty < RTY_W'(MAX_RETRIES));

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state    <= IDLE;
      r_tmr      <= '0;
      r_rty      <= '0;
      r_seq      <= 1'b0;
      r_tx_start <= 1'b0;
      r_done     <= 1'b0;
      r_fail     <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_done     <= 1'b0;
      r_fail     <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (send_req) begin
            r_state    <= SEND;
            r_rty      <= '0;
            r_tx_start <= 1'b1;
          end
        end
        SEND: begin
          r_state <= WAIT_TX;
        end
        WAIT_TX: begin
          if (tx_done) begin
            r_state <= WAIT_ACK;
            r_tmr   <= '0;
          end
        end
        WAIT_ACK: begin
          r_tmr <= r_tmr + TMR_W'(1);
          // ACK beats timeout when both land in the same cycle
          if (w_ack_match) begin
            r_done  <= 1'b1;
            r_seq   <= ~r_seq;
            r_state <= IDLE;
          end else if (w_timeout) begin
            if (w_can_retry) begin
              r_rty      <= r_rty + RTY_W'(1);
              r_tx_start <= 1'b1;
              r_state    <= SEND;
            end else begin
              r_fail  <= 1'b1;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign send_ready = (r_state == IDLE);
  assign tx_start   = r_tx_start;
  assign tx_seq_num = r_seq;
  assign send_done  = r_done;
  assign send_fail  = r_fail;
  assign retry_cnt  = r_rty;

endmodule

// File: tb/tb_tx_handshake_ctrl.sv
// tb_tx_handshake_ctrl: directed vectors for tx_handshake_ctrl.
// Cycle k is the interval after the k-th rising edge; checks sit at +1.
`timescale 1ns/1ps
module tb_tx_handshake_ctrl;

  logic clk = 1'b0;
  logic rst_l;
  logic send_req;
  logic send_ready;
  logic tx_start;
  logic tx_seq_num;
  logic tx_done;
  logic ack_valid;
  logic ack_pid;
  logic ack_seq_num;
  logic send_done;
  logic send_fail;
  logic [2:0] retry_cnt;

  int n_vec = 0;
  int n_err = 0;
  int n_start = 0;
  int n_done = 0;
  int n_fail = 0;
  int n_both = 0;

  always #5 clk = ~clk;

  tx_handshake_ctrl #(
    .TIMEOUT_CYCLES(100),
    .MAX_RETRIES(3)
  ) dut (
    .clk(clk),
    .rst_l(rst_l),
    .send_req(send_req),
    .send_ready(send_ready),
    .tx_start(tx_start),
    .tx_seq_num(tx_seq_num),
    .tx_done(tx_done),
    .ack_valid(ack_valid),
    .ack_pid(ack_pid),
    .ack_seq_num(ack_seq_num),
    .send_done(send_done),
    .send_fail(send_fail),
    .retry_cnt(retry_cnt)
  );

  always @(negedge clk) begin
    if (rst_l) begin
      n_start += int'(tx_start);
      n_done  += int'(send_done);
      n_fail  += int'(send_fail);
      n_both  += int'(send_done & send_fail);
    end
  end

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic done_pulse();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  task automatic ack_pulse(input logic p, input logic s);
    ack_valid   = 1'b1;
    ack_pid     = p;
    ack_seq_num = s;
    step();
    ack_valid   = 1'b0;
    ack_pid     = 1'b0;
    ack_seq_num = 1'b0;
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    step(2);
    rst_l = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int d0;
    int f0;
    int starts;
    int pend;
    int cyc;
    int tdone_cyc;
    bit seen;

    rst_l = 1'b0;
    send_req = 1'b0;
    tx_done = 1'b0;
    ack_valid = 1'b0;
    ack_pid = 1'b0;
    ack_seq_num = 1'b0;
    step(2);
    check_eq("rst_ready", send_ready, 1);
    check_eq("rst_start", tx_start, 0);
    check_eq("rst_seq", tx_seq_num, 0);
    check_eq("rst_done", send_done, 0);
    check_eq("rst_fail", send_fail, 0);
    check_eq("rst_retry", retry_cnt, 0);
    rst_l = 1'b1;

    // 1: basic success, ACK seq0 at c20
    send_req = 1'b1;
    check_eq("t1_ready_c0", send_ready, 1);
    step();
    send_req = 1'b0;
    check_eq("t1_start_c1", tx_start, 1);
    check_eq("t1_ready_c1", send_ready, 0);
    step();
    check_eq("t1_start_c2", tx_start, 0);
    step(3);
    done_pulse();
    step(14);
    ack_pulse(1'b1, 1'b0);
    check_eq("t1_done_c21", send_done, 1);
    check_eq("t1_seq_c21", tx_seq_num, 1);
    check_eq("t1_ready_c21", send_ready, 1);
    check_eq("t1_nstart", n_start, 1);
    step();
    check_eq("t1_done_c22", send_done, 0);

    // 2+3: no ACK ever, resend gap and final failure
    do_reset();
    check_eq("t3_seq_rst", tx_seq_num, 0);
    d0 = n_done;
    send_req = 1'b1;
    step();
    send_req = 1'b0;
    starts = 0;
    pend = 0;
    cyc = 1;
    tdone_cyc = -1;
    seen = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if (tx_start) begin
        starts++;
        pend = 3;
        if (starts == 2) begin
          check_eq("t2_gap", cyc - tdone_cyc, 101);
          check_eq("t2_retry", retry_cnt, 1);
          check_eq("t2_seq", tx_seq_num, 0);
        end
      end
      tx_done = (pend == 1);
      if (tx_done && tdone_cyc < 0) tdone_cyc = cyc;
      if (pend > 0) pend--;
      if (send_fail) begin
        seen = 1'b1;
        break;
      end
      step();
      cyc++;
    end
    tx_done = 1'b0;
    check_eq("t3_fail_seen", seen, 1);
    check_eq("t3_starts", starts, 4);
    check_eq("t3_retry", retry_cnt, 3);
    check_eq("t3_seq", tx_seq_num, 0);
    check_eq("t3_ready", send_ready, 1);
    step();
    check_eq("t3_fail_1cyc", send_fail, 0);
    check_eq("t3_retry_held", retry_cnt, 3);
    check_eq("t3_nfail", n_fail, 1);
    check_eq("t3_ndone", n_done - d0, 0);

    // 4a: ACK in WAIT_TX, wrong seq, PID_GE all ignored
    send_req = 1'b1;
    step();
    send_req = 1'b0;
    check_eq("t4_retry_clr", retry_cnt, 0);
    step();
    ack_pulse(1'b1, 1'b0);
    check_eq("t4_waittx_ack", send_done, 0);
    step(2);
    done_pulse();
    step(4);
    ack_pulse(1'b1, 1'b1);
    ack_pulse(1'b0, 1'b0);
    check_eq("t4_bad_ack_done", send_done, 0);
    check_eq("t4_bad_ack_ready", send_ready, 0);
    step();
    check_eq("t4_bad_ack_done2", send_done, 0);
    ack_pulse(1'b1, 1'b0);
    check_eq("t4_good_done", send_done, 1);
    check_eq("t4_good_seq", tx_seq_num, 1);

    // 4b: matching ACK in the timeout cycle c105
    send_req = 1'b1;
    step();
    send_req = 1'b0;
    step(4);
    done_pulse();
    step(99);
    s0 = n_start;
    ack_pulse(1'b1, 1'b1);
    check_eq("t4_to_done", send_done, 1);
    check_eq("t4_to_start", tx_start, 0);
    check_eq("t4_to_seq", tx_seq_num, 0);
    check_eq("t4_to_retry", retry_cnt, 0);
    step(3);
    check_eq("t4_to_nstart", n_start - s0, 0);
    check_eq("t4_to_ready", send_ready, 1);

    // 5: send_req held across the whole exchange
    send_req = 1'b1;
    step();
    check_eq("t5_start_c1", tx_start, 1);
    check_eq("t5_seq_c1", tx_seq_num, 0);
    step();
    s0 = n_start;
    step(3);
    done_pulse();
    step(4);
    ack_pulse(1'b1, 1'b0);
    check_eq("t5_done", send_done, 1);
    check_eq("t5_seq", tx_seq_num, 1);
    check_eq("t5_ready", send_ready, 1);
    check_eq("t5_no_extra", n_start - s0, 0);
    step();
    check_eq("t5_restart", tx_start, 1);
    check_eq("t5_restart_seq", tx_seq_num, 1);
    check_eq("t5_busy", send_ready, 0);
    send_req = 1'b0;
    step();
    done_pulse();
    step(3);

    // 6: async reset in WAIT_ACK
    d0 = n_done;
    f0 = n_fail;
    #2;
    rst_l = 1'b0;
    #1;
    check_eq("t6_ready", send_ready, 1);
    check_eq("t6_seq", tx_seq_num, 0);
    check_eq("t6_start", tx_start, 0);
    check_eq("t6_done", send_done, 0);
    check_eq("t6_fail", send_fail, 0);
    check_eq("t6_retry", retry_cnt, 0);
    step(2);
    rst_l = 1'b1;
    ack_pulse(1'b1, 1'b0);
    ack_pulse(1'b1, 1'b1);
    step(150);
    check_eq("t6_ndone", n_done - d0, 0);
    check_eq("t6_nfail", n_fail - f0, 0);
    check_eq("t6_idle", send_ready, 1);
    check_eq("both_never", n_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
